cfg_regfile: RTL

- Parametrised successor of the configuration register file, sitting between the SPI memory interface and the FIFO, IRQ, DAC and bias logic.
- Adds parametrised DAC/bias counts and widths, per-field access types (RW, RO, W1C, pulse, set-only), a sticky IRQ status/enable pair with a registered interrupt output, and a configuration lock.
- Optionally adds double-buffered DAC/bias outputs applied atomically on a commit.

---
 rtl/cfg_rf_pkg.sv | 40 ++++
 rtl/cfg_rf_irq_status.sv | 38 +++
 rtl/cfg_regfile.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cfg_rf_pkg.sv
// Shared constants for the configuration register file: byte map, CTRL bits,
// address helpers and the field access-type enum.
package cfg_rf_pkg;

  localparam int ROW_BYTES = 4;

  localparam int ADDR_CHIP_ID      = 'h00;
  localparam int ADDR_FIFO_RST     = 'h01;
  localparam int ADDR_FIFO_NUMEL   = 'h04;
  localparam int ADDR_FIFO_RD      = 'h08;
  localparam int ADDR_IRQ_DEASSERT = 'h0C;
  localparam int ADDR_IRQ_ASSERT   = 'h0E;
  localparam int ADDR_IRQ_STATUS   = 'h10;
  localparam int ADDR_IRQ_ENABLE   = 'h14;
  localparam int ADDR_CTRL         = 'h18;
  localparam int ADDR_EVENT_RATE   = 'h1C;
  localparam int ADDR_DAC_BASE     = 'h20;
  localparam int ADDR_BIAS_BASE    = 'h40;

  localparam logic [7:0] CHIP_ID = 8'hC5;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_LOCK_BIT   = 8;

  localparam int THRESH_WIDTH = 10;
  localparam int EVENT_WIDTH  = 10;
  localparam int BIAS_WIDTH   = 24;

  typedef enum logic [2:0] {RW, RO, W1C, PULSE, SET_ONLY} access_e;

  // Row index and bit offset within the row of a byte address
  function automatic int ROW_DIV(input int byte_addr);
    return byte_addr / ROW_BYTES;
  endfunction

  function automatic int LSB_DIV(input int byte_addr);
    return (byte_addr % ROW_BYTES) * 8;
  endfunction

endpackage

// File: rtl/cfg_rf_irq_status.sv
// Sticky interrupt status (set by level sources, cleared by write-1), the
// interrupt enable register and the registered interrupt output.
module cfg_rf_irq_status #(
  parameter int NUM_IRQ_SRC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_IRQ_SRC-1:0] irq_src,
  input  logic [NUM_IRQ_SRC-1:0] clr_mask,
  input  logic [NUM_IRQ_SRC-1:0] en_mask,
  input  logic [NUM_IRQ_SRC-1:0] en_wdata,
  output logic [NUM_IRQ_SRC-1:0] status,
  output logic [NUM_IRQ_SRC-1:0] enable,
  output logic                   irq
);

  logic [NUM_IRQ_SRC-1:0] status_reg;
  logic [NUM_IRQ_SRC-1:0] enable_reg;
  logic                   irq_reg;

  // Source set is OR-ed after the clear so a simultaneous set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_reg <= '0;
      enable_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      status_reg <= (status_reg & ~clr_mask) | irq_src;
      enable_reg <= (enable_reg & ~en_mask) | (en_wdata & en_mask);
      irq_reg    <= |(status_reg & enable_reg);
    end
  end

  assign status = status_reg;
  assign enable = enable_reg;
  assign irq    = irq_reg;

endmodule

// File: rtl/cfg_regfile.sv
// Configuration register file between the SPI memory interface and the FIFO/IRQ/DAC/bias logic.
// Define CFG_RF_SHADOW_EN to double-buffer DAC/bias outputs behind a CTRL.COMMIT write.
module cfg_regfile
  import cfg_rf_pkg::*;
#(
  parameter int RF_AWIDTH   = 5,
  parameter int RF_WIDTH    = 32,
  parameter int NUM_DACS    = 8,
  parameter int DAC_WIDTH   = 10,
  parameter int NUM_BIASES  = 4,
  parameter int NUM_IRQ_SRC = 4,
  parameter int FIFO_AWIDTH = 10,
  localparam int RF_MASK    = RF_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [RF_AWIDTH-1:0]             addr,
  input  logic                             we,
  input  logic [RF_WIDTH-1:0]              wdata,
  input  logic [RF_MASK-1:0]               wmask,
  output logic [RF_WIDTH-1:0]              rdata,
  output logic                             fifo_rst_n,
  output logic                             fifo_rd_en,
  input  logic [FIFO_AWIDTH-1:0]           fifo_numel,
  output logic [THRESH_WIDTH-1:0]          irq_deassert_thresh,
  output logic [THRESH_WIDTH-1:0]          irq_assert_thresh,
  input  logic [NUM_IRQ_SRC-1:0]           irq_src,
  output logic                             irq,
  input  logic [EVENT_WIDTH-1:0]           event_rate,
  output logic [NUM_DACS*DAC_WIDTH-1:0]    dac_config,
  output logic [NUM_BIASES*BIAS_WIDTH-1:0] bias
);

  localparam logic [RF_AWIDTH-1:0] ROW_CHIP_ID    = RF_AWIDTH'(ROW_DIV(ADDR_CHIP_ID));
  localparam logic [RF_AWIDTH-1:0] ROW_FIFO_RST   = RF_AWIDTH'(ROW_DIV(ADDR_FIFO_RST));
  localparam logic [RF_AWIDTH-1:0] ROW_FIFO_NUMEL = RF_AWIDTH'(ROW_DIV(ADDR_FIFO_NUMEL));
  localparam logic [RF_AWIDTH-1:0] ROW_FIFO_RD    = RF_AWIDTH'(ROW_DIV(ADDR_FIFO_RD));
  localparam logic [RF_AWIDTH-1:0] ROW_DEASSERT   = RF_AWIDTH'(ROW_DIV(ADDR_IRQ_DEASSERT));
  localparam logic [RF_AWIDTH-1:0] ROW_ASSERT     = RF_AWIDTH'(ROW_DIV(ADDR_IRQ_ASSERT));
  localparam logic [RF_AWIDTH-1:0] ROW_STATUS     = RF_AWIDTH'(ROW_DIV(ADDR_IRQ_STATUS));
  localparam logic [RF_AWIDTH-1:0] ROW_ENABLE     = RF_AWIDTH'(ROW_DIV(ADDR_IRQ_ENABLE));
  localparam logic [RF_AWIDTH-1:0] ROW_CTRL       = RF_AWIDTH'(ROW_DIV(ADDR_CTRL));
  localparam logic [RF_AWIDTH-1:0] ROW_EVENT      = RF_AWIDTH'(ROW_DIV(ADDR_EVENT_RATE));
  localparam int LANE_FIFO_RST = LSB_DIV(ADDR_FIFO_RST) / 8;
  localparam int LANE_FIFO_RD  = LSB_DIV(ADDR_FIFO_RD) / 8;
  localparam int LSB_DEASSERT  = LSB_DIV(ADDR_IRQ_DEASSERT);
  localparam int LSB_ASSERT    = LSB_DIV(ADDR_IRQ_ASSERT);

  logic [RF_WIDTH-1:0]     wbits;
  logic                    cfg_wr_ok;
  logic                    wr_ctrl;
  logic                    lock_reg;
  logic                    fifo_rst_n_reg;
  logic                    fifo_rd_en_reg;
  logic [THRESH_WIDTH-1:0] deassert_reg;
  logic [THRESH_WIDTH-1:0] assert_reg;
  logic [NUM_IRQ_SRC-1:0]  irq_status;
  logic [NUM_IRQ_SRC-1:0]  irq_enable;
  logic [NUM_IRQ_SRC-1:0]  clr_mask;
  logic [NUM_IRQ_SRC-1:0]  en_mask;
  logic [RF_WIDTH-1:0]     dac_rd  [NUM_DACS];
  logic [RF_WIDTH-1:0]     bias_rd [NUM_BIASES];
  logic [RF_WIDTH-1:0]     rd_fixed;
  logic                    commit_reg;
  logic                    unused_bits;

  // Expand byte-lane enables to a per-bit write mask
  for (genvar gi = 0; gi < RF_WIDTH; gi++) begin : g_wbits
    assign wbits[gi] = wmask[gi/8];
  end

  assign cfg_wr_ok = we && !lock_reg;
  assign wr_ctrl   = we && (addr == ROW_CTRL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg       <= 1'b0;
      fifo_rst_n_reg <= 1'b0;
      fifo_rd_en_reg <= 1'b0;
      deassert_reg   <= '0;
      assert_reg     <= '0;
      commit_reg     <= 1'b0;
    end else begin
      if (wr_ctrl && wbits[CTRL_LOCK_BIT] && wdata[CTRL_LOCK_BIT])
        lock_reg <= 1'b1;
      fifo_rst_n_reg <= !(we && (addr == ROW_FIFO_RST) && wmask[LANE_FIFO_RST]);
      fifo_rd_en_reg <= we && (addr == ROW_FIFO_RD) && wmask[LANE_FIFO_RD];
      commit_reg     <= wr_ctrl && wbits[CTRL_COMMIT_BIT] && wdata[CTRL_COMMIT_BIT];
      if (cfg_wr_ok && (addr == ROW_DEASSERT))
        deassert_reg <= (deassert_reg & ~wbits[LSB_DEASSERT +: THRESH_WIDTH])
                      | (wdata[LSB_DEASSERT +: THRESH_WIDTH] & wbits[LSB_DEASSERT +: THRESH_WIDTH]);
      if (cfg_wr_ok && (addr == ROW_ASSERT))
        assert_reg <= (assert_reg & ~wbits[LSB_ASSERT +: THRESH_WIDTH])
                    | (wdata[LSB_ASSERT +: THRESH_WIDTH] & wbits[LSB_ASSERT +: THRESH_WIDTH]);
    end
  end

  assign clr_mask = (we && (addr == ROW_STATUS)) ? (wdata[NUM_IRQ_SRC-1:0] & wbits[NUM_IRQ_SRC-1:0]) : '0;
  assign en_mask  = (cfg_wr_ok && (addr == ROW_ENABLE)) ? wbits[NUM_IRQ_SRC-1:0] : '0;

  cfg_rf_irq_status #(
    .NUM_IRQ_SRC(NUM_IRQ_SRC)
  ) u_irq_status (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .clr_mask (clr_mask),
    .en_mask  (en_mask),
    .en_wdata (wdata[NUM_IRQ_SRC-1:0]),
    .status   (irq_status),
    .enable   (irq_enable),
    .irq      (irq)
  );

  for (genvar gi = 0; gi < NUM_DACS; gi++) begin : g_dac
    localparam int BYTE_ADDR = ADDR_DAC_BASE + 2*gi;
    localparam logic [RF_AWIDTH-1:0] ROW = RF_AWIDTH'(ROW_DIV(BYTE_ADDR));
    localparam int LSB = LSB_DIV(BYTE_ADDR);
    logic [DAC_WIDTH-1:0] stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stage_reg <= '0;
      else if (cfg_wr_ok && (addr == ROW))
        stage_reg <= (stage_reg & ~wbits[LSB +: DAC_WIDTH]) | (wdata[LSB +: DAC_WIDTH] & wbits[LSB +: DAC_WIDTH]);
    end

    assign dac_rd[gi] = (addr == ROW) ? (RF_WIDTH'(stage_reg) << LSB) : '0;

`ifdef CFG_RF_SHADOW_EN
    logic [DAC_WIDTH-1:0] live_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        live_reg <= '0;
      else if (commit_reg)
        live_reg <= stage_reg;
    end
    assign dac_config[gi*DAC_WIDTH +: DAC_WIDTH] = live_reg;
`else
    assign dac_config[gi*DAC_WIDTH +: DAC_WIDTH] = stage_reg;
`endif
  end

  for (genvar gi = 0; gi < NUM_BIASES; gi++) begin : g_bias
    localparam logic [RF_AWIDTH-1:0] ROW = RF_AWIDTH'(ROW_DIV(ADDR_BIAS_BASE + 4*gi));
    logic [BIAS_WIDTH-1:0] stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stage_reg <= '0;
      else if (cfg_wr_ok && (addr == ROW))
        stage_reg <= (stage_reg & ~wbits[BIAS_WIDTH-1:0]) | (wdata[BIAS_WIDTH-1:0] & wbits[BIAS_WIDTH-1:0]);
    end

    assign bias_rd[gi] = (addr == ROW) ? RF_WIDTH'(stage_reg) : '0;

`ifdef CFG_RF_SHADOW_EN
    logic [BIAS_WIDTH-1:0] live_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        live_reg <= '0;
      else if (commit_reg)
        live_reg <= stage_reg;
    end
    assign bias[gi*BIAS_WIDTH +: BIAS_WIDTH] = live_reg;
`else
    assign bias[gi*BIAS_WIDTH +: BIAS_WIDTH] = stage_reg;
`endif
  end

  always_comb begin
    rd_fixed = '0;
    case (addr)
      ROW_CHIP_ID:    rd_fixed[7:0] = CHIP_ID;
      ROW_FIFO_NUMEL: rd_fixed[FIFO_AWIDTH-1:0] = fifo_numel;
      ROW_DEASSERT: begin
        rd_fixed[LSB_DEASSERT +: THRESH_WIDTH] = deassert_reg;
        rd_fixed[LSB_ASSERT +: THRESH_WIDTH]   = assert_reg;
      end
      ROW_STATUS:     rd_fixed[NUM_IRQ_SRC-1:0] = irq_status;
      ROW_ENABLE:     rd_fixed[NUM_IRQ_SRC-1:0] = irq_enable;
      ROW_CTRL:       rd_fixed[CTRL_LOCK_BIT] = lock_reg;
      ROW_EVENT:      rd_fixed[EVENT_WIDTH-1:0] = event_rate;
      default:        rd_fixed = '0;
    endcase
    rdata = rd_fixed;
    for (int i = 0; i < NUM_DACS; i++)
      rdata = rdata | dac_rd[i];
    for (int i = 0; i < NUM_BIASES; i++)
      rdata = rdata | bias_rd[i];
  end

  assign fifo_rst_n          = fifo_rst_n_reg;
  assign fifo_rd_en          = fifo_rd_en_reg;
  assign irq_deassert_thresh = deassert_reg;
  assign irq_assert_thresh   = assert_reg;

  // Commit is only consumed by the shadowed build; upper data bits map to no field
  assign unused_bits = ^{wdata, wbits, commit_reg};

endmodule
